// File: rtl/alu_seq_pkg.sv
// Shared definitions for the ALU operand sequencer: state encoding,
// default data width and the EXEC counter width helper.
package alu_seq_pkg;

  localparam int LENGTH_V_DEFAULT = 8;
  localparam int STATE_W          = 3;

  // Codes 6 and 7 are unused; the FSM returns to S_LOAD_A from them.
  typedef enum logic [STATE_W-1:0] {
    S_LOAD_A  = 3'd0,
    S_LOAD_B  = 3'd1,
    S_LOAD_OP = 3'd2,
    S_EXEC    = 3'd3,
    S_CAPTURE = 3'd4,
    S_DONE    = 3'd5
  } state_e;

  // Counter width able to hold exec_cycles, never narrower than one bit.
  function automatic int cnt_width(input int exec_cycles);
    int w;
    w = $clog2(exec_cycles + 1);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/alu_operand_sequencer_load_edge_sync.sv
// load_edge_sync: two-flop synchronizer for the asynchronous load pin
// followed by a rising-edge detector. rise_o is high for one cycle per
// 0->1 transition, two clocks after the pin rises.
module load_edge_sync (
  input  logic clock,
  input  logic reset,
  input  logic load_i,
  output logic rise_o
);

  logic sync1_q, sync2_q, prev_q;

  // Synchronize load and keep the previous synchronized level.
  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge value of its neighbour, as real flops do.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      prev_q  <= 1'b0;
    end else begin
      sync1_q <= load_i;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
    end
  end

  assign rise_o = sync2_q & ~prev_q;

endmodule

// File: rtl/alu_operand_sequencer.sv
// alu_operand_sequencer: sequences loads of operand A, operand B and the
// opcode from one shared data bus, waits the ALU latency and then pulses
// the result register enable. All outputs are registered.
// Optional build macro LOAD_EDGE_EN: load is synchronized and
// edge-detected (one accept per rising edge, two cycles extra latency);
// otherwise load is level-sampled.
module alu_operand_sequencer
  import alu_seq_pkg::*;
#(
  parameter int LENGTH_v    = LENGTH_V_DEFAULT,
  parameter int EXEC_CYCLES = 1
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                load,
  input  logic                abort,
  input  logic [LENGTH_v-1:0] data_in,
  output logic [LENGTH_v-1:0] reg_d,
  output logic                en_a,
  output logic                en_b,
  output logic                en_op,
  output logic                en_res,
  output logic                busy,
  output logic                done,
  output logic [STATE_W-1:0]  state_o
);

  localparam int                EXEC_EFF = (EXEC_CYCLES < 1) ? 1 : EXEC_CYCLES;
  localparam int                CNT_W    = cnt_width(EXEC_EFF);
  localparam logic [CNT_W-1:0]  CNT_LOAD = CNT_W'(EXEC_EFF - 1);

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [LENGTH_v-1:0] reg_d_q, reg_d_d;
  logic                en_a_q, en_a_d, en_b_q, en_b_d;
  logic                en_op_q, en_op_d, en_res_q, en_res_d;
  logic                busy_q, busy_d, done_q, done_d;
  logic                accept;

`ifdef LOAD_EDGE_EN
  load_edge_sync u_load_edge_sync (
    .clock  (clock),
    .reset  (reset),
    .load_i (load),
    .rise_o (accept)
  );
`else
  assign accept = load;
`endif

  // Next-state, counter and registered-output decode.
  // NOTE: every variable gets a default before the case so no path
  // leaves one unassigned, which would infer a latch.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    reg_d_d  = reg_d_q;
    en_a_d   = 1'b0;
    en_b_d   = 1'b0;
    en_op_d  = 1'b0;
    en_res_d = 1'b0;

    if (abort) begin
      state_d = S_LOAD_A;
      cnt_d   = '0;
    end else begin
      case (state_q)
        S_LOAD_A, S_DONE: begin
          if (accept) begin
            reg_d_d = data_in;
            en_a_d  = 1'b1;
            state_d = S_LOAD_B;
          end
        end
        S_LOAD_B: begin
          if (accept) begin
            reg_d_d = data_in;
            en_b_d  = 1'b1;
            state_d = S_LOAD_OP;
          end
        end
        S_LOAD_OP: begin
          if (accept) begin
            reg_d_d = data_in;
            en_op_d = 1'b1;
            cnt_d   = CNT_LOAD;
            state_d = S_EXEC;
          end
        end
        S_EXEC: begin
          if (cnt_q == '0) begin
            en_res_d = 1'b1;
            state_d  = S_CAPTURE;
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
        S_CAPTURE: state_d = S_DONE;
        default: begin
          state_d = S_LOAD_A;
          cnt_d   = '0;
        end
      endcase
    end

    // Status flags follow the state being entered so they are registered.
    busy_d = (state_d == S_EXEC) || (state_d == S_CAPTURE);
    done_d = (state_d == S_DONE);
  end

  // State, counter and output registers with asynchronous reset.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= S_LOAD_A;
      cnt_q    <= '0;
      reg_d_q  <= '0;
      en_a_q   <= 1'b0;
      en_b_q   <= 1'b0;
      en_op_q  <= 1'b0;
      en_res_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      reg_d_q  <= reg_d_d;
      en_a_q   <= en_a_d;
      en_b_q   <= en_b_d;
      en_op_q  <= en_op_d;
      en_res_q <= en_res_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign reg_d   = reg_d_q;
  assign en_a    = en_a_q;
  assign en_b    = en_b_q;
  assign en_op   = en_op_q;
  assign en_res  = en_res_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign state_o = state_q;

endmodule
